// File: rtl/rv_defs.sv
// Shared RV32I decode definitions: opcodes, ALU operation codes (base and M),
// result-source encodings, immediate formats and the decoded control word.
package rv_defs;

    localparam int unsigned ALU_W = 5;

    localparam logic [6:0] OPC_OP     = 7'h33;
    localparam logic [6:0] OPC_OP_IMM = 7'h13;
    localparam logic [6:0] OPC_LOAD   = 7'h03;
    localparam logic [6:0] OPC_STORE  = 7'h23;
    localparam logic [6:0] OPC_BRANCH = 7'h63;
    localparam logic [6:0] OPC_JAL    = 7'h6F;
    localparam logic [6:0] OPC_JALR   = 7'h67;
    localparam logic [6:0] OPC_LUI    = 7'h37;
    localparam logic [6:0] OPC_AUIPC  = 7'h17;

    localparam logic [ALU_W-1:0] ALU_ADD    = 5'd0;
    localparam logic [ALU_W-1:0] ALU_SUB    = 5'd1;
    localparam logic [ALU_W-1:0] ALU_SLL    = 5'd2;
    localparam logic [ALU_W-1:0] ALU_SLT    = 5'd3;
    localparam logic [ALU_W-1:0] ALU_SLTU   = 5'd4;
    localparam logic [ALU_W-1:0] ALU_XOR    = 5'd5;
    localparam logic [ALU_W-1:0] ALU_SRL    = 5'd6;
    localparam logic [ALU_W-1:0] ALU_SRA    = 5'd7;
    localparam logic [ALU_W-1:0] ALU_OR     = 5'd8;
    localparam logic [ALU_W-1:0] ALU_AND    = 5'd9;
    localparam logic [ALU_W-1:0] ALU_MUL    = 5'd16;
    localparam logic [ALU_W-1:0] ALU_MULH   = 5'd17;
    localparam logic [ALU_W-1:0] ALU_MULHSU = 5'd18;
    localparam logic [ALU_W-1:0] ALU_MULHU  = 5'd19;
    localparam logic [ALU_W-1:0] ALU_DIV    = 5'd20;
    localparam logic [ALU_W-1:0] ALU_DIVU   = 5'd21;
    localparam logic [ALU_W-1:0] ALU_REM    = 5'd22;
    localparam logic [ALU_W-1:0] ALU_REMU   = 5'd23;

    localparam logic [1:0] RES_ALU = 2'd0;
    localparam logic [1:0] RES_MEM = 2'd1;
    localparam logic [1:0] RES_PC4 = 2'd2;

    typedef enum logic [2:0] {
        IMM_NONE,
        IMM_I,
        IMM_S,
        IMM_B,
        IMM_U,
        IMM_J
    } imm_fmt_e;

    typedef struct packed {
        logic [4:0]       rs1;
        logic [4:0]       rs2;
        logic [4:0]       rd;
        logic [2:0]       funct3;
        logic [ALU_W-1:0] alu_ctrl;
        logic             alu_src;
        logic             alu_a_pc;
        logic [1:0]       res_src;
        logic             mem_we;
        logic             mem_re;
        logic             reg_we;
        logic             branch;
        logic             jump;
        logic             jalr;
        logic             illegal;
    } ctrl_t;

    // Register/immediate ALU op from funct3; alt selects SUB/SRA.
    function automatic logic [ALU_W-1:0] alu_base(input logic [2:0] f3, input logic alt);
        logic [ALU_W-1:0] op;
        case (f3)
            3'd0:    op = alt ? ALU_SUB : ALU_ADD;
            3'd1:    op = ALU_SLL;
            3'd2:    op = ALU_SLT;
            3'd3:    op = ALU_SLTU;
            3'd4:    op = ALU_XOR;
            3'd5:    op = alt ? ALU_SRA : ALU_SRL;
            3'd6:    op = ALU_OR;
            default: op = ALU_AND;
        endcase
        return op;
    endfunction

    // M-extension codes are laid out in funct3 order starting at ALU_MUL.
    function automatic logic [ALU_W-1:0] alu_mext(input logic [2:0] f3);
        return ALU_MUL | ALU_W'(f3);
    endfunction

endpackage

// File: rtl/rv_imm_gen.sv
// Combinational RV32 immediate extractor; sign-extends the selected format to XLEN.
module rv_imm_gen
    import rv_defs::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic [31:7]     instr,
    input  imm_fmt_e        fmt,
    output logic [XLEN-1:0] imm
);

    logic [31:0] imm32;

    always_comb begin
        imm32 = '0;
        case (fmt)
            IMM_I:   imm32 = {{20{instr[31]}}, instr[31:20]};
            IMM_S:   imm32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            IMM_B:   imm32 = {{19{instr[31]}}, instr[31], instr[7], instr[30:25],
                              instr[11:8], 1'b0};
            IMM_U:   imm32 = {instr[31:12], 12'h000};
            IMM_J:   imm32 = {{11{instr[31]}}, instr[31], instr[19:12], instr[20],
                              instr[30:21], 1'b0};
            default: imm32 = '0;
        endcase
    end

    assign imm = XLEN'($signed(imm32));

endmodule

// File: rtl/rv_decode_stage.sv
// Registered, handshaked RV32I decode stage with flush and illegal flagging.
// Define RV_M_EXT_EN to decode the M extension; otherwise it is flagged illegal.
module rv_decode_stage
    import rv_defs::*;
#(
    parameter int unsigned XLEN       = 32,
    parameter int unsigned ALU_CTRL_W = 5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [31:0]           in_instr,
    input  logic [XLEN-1:0]       in_pc,
    input  logic                  flush,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [XLEN-1:0]       out_pc,
    output logic [4:0]            rs1,
    output logic [4:0]            rs2,
    output logic [4:0]            rd,
    output logic [2:0]            funct3,
    output logic [XLEN-1:0]       imm,
    output logic [ALU_CTRL_W-1:0] alu_ctrl,
    output logic                  alu_src,
    output logic                  alu_a_pc,
    output logic [1:0]            res_src,
    output logic                  mem_we,
    output logic                  mem_re,
    output logic                  reg_we,
    output logic                  branch,
    output logic                  jump,
    output logic                  jalr,
    output logic                  illegal
);

    logic [6:0]      opcode;
    logic [2:0]      f3;
    logic [6:0]      f7;
    ctrl_t           dec;
    imm_fmt_e        fmt;
    logic            bad;
    logic            wr;
    logic [XLEN-1:0] imm_d;

    logic            valid_q;
    ctrl_t           ctrl_q;
    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] imm_q;
    logic            load;

    assign opcode = in_instr[6:0];
    assign f3     = in_instr[14:12];
    assign f7     = in_instr[31:25];

    // Instruction decode into the control word and immediate format.
    always_comb begin
        dec          = '0;
        fmt          = IMM_NONE;
        bad          = 1'b0;
        wr           = 1'b0;
        dec.rs1      = in_instr[19:15];
        dec.rs2      = in_instr[24:20];
        dec.rd       = in_instr[11:7];
        dec.funct3   = f3;
        dec.alu_ctrl = ALU_ADD;
        dec.res_src  = RES_ALU;
        case (opcode)
            OPC_OP: begin
                wr = 1'b1;
                if (f7 == 7'h00) begin
                    dec.alu_ctrl = alu_base(f3, 1'b0);
                end else if (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5)) begin
                    dec.alu_ctrl = alu_base(f3, 1'b1);
`ifdef RV_M_EXT_EN
                end else if (f7 == 7'h01) begin
                    dec.alu_ctrl = alu_mext(f3);
`endif
                end else begin
                    bad = 1'b1;
                end
            end
            OPC_OP_IMM: begin
                wr          = 1'b1;
                fmt         = IMM_I;
                dec.alu_src = 1'b1;
                // Shifts carry a shamt in [24:20]; the upper bits must be a known pattern.
                if (f3 == 3'd1) begin
                    dec.alu_ctrl = ALU_SLL;
                    bad          = (f7 != 7'h00);
                end else if (f3 == 3'd5) begin
                    dec.alu_ctrl = in_instr[30] ? ALU_SRA : ALU_SRL;
                    bad          = (f7 != 7'h00) && (f7 != 7'h20);
                end else begin
                    dec.alu_ctrl = alu_base(f3, 1'b0);
                end
            end
            OPC_LOAD: begin
                wr          = 1'b1;
                fmt         = IMM_I;
                dec.alu_src = 1'b1;
                dec.mem_re  = 1'b1;
                dec.res_src = RES_MEM;
                bad         = (f3 == 3'd3) || (f3 == 3'd6) || (f3 == 3'd7);
            end
            OPC_STORE: begin
                fmt         = IMM_S;
                dec.alu_src = 1'b1;
                dec.mem_we  = 1'b1;
                bad         = (f3 > 3'd2);
            end
            OPC_BRANCH: begin
                fmt        = IMM_B;
                dec.branch = 1'b1;
                case (f3)
                    3'd0, 3'd1: dec.alu_ctrl = ALU_SUB;
                    3'd4, 3'd5: dec.alu_ctrl = ALU_SLT;
                    3'd6, 3'd7: dec.alu_ctrl = ALU_SLTU;
                    default:    bad = 1'b1;
                endcase
            end
            OPC_JAL: begin
                wr           = 1'b1;
                fmt          = IMM_J;
                dec.jump     = 1'b1;
                dec.alu_src  = 1'b1;
                dec.alu_a_pc = 1'b1;
                dec.res_src  = RES_PC4;
            end
            OPC_JALR: begin
                wr          = 1'b1;
                fmt         = IMM_I;
                dec.jump    = 1'b1;
                dec.jalr    = 1'b1;
                dec.alu_src = 1'b1;
                dec.res_src = RES_PC4;
                bad         = (f3 != 3'd0);
            end
            OPC_LUI: begin
                wr          = 1'b1;
                fmt         = IMM_U;
                dec.alu_src = 1'b1;
                dec.rs1     = 5'd0;
            end
            OPC_AUIPC: begin
                wr           = 1'b1;
                fmt          = IMM_U;
                dec.alu_src  = 1'b1;
                dec.alu_a_pc = 1'b1;
            end
            default: bad = 1'b1;
        endcase
        if (in_instr[1:0] != 2'b11) begin
            bad = 1'b1;
        end
        dec.reg_we  = wr && (dec.rd != 5'd0) && !bad;
        dec.illegal = bad;
        // Illegal beats travel on harmlessly so the exception is raised downstream.
        if (bad) begin
            dec.mem_we = 1'b0;
            dec.mem_re = 1'b0;
            dec.branch = 1'b0;
            dec.jump   = 1'b0;
            dec.jalr   = 1'b0;
        end
    end

    rv_imm_gen #(
        .XLEN(XLEN)
    ) u_imm_gen (
        .instr(in_instr[31:7]),
        .fmt  (fmt),
        .imm  (imm_d)
    );

    assign in_ready = !valid_q || out_ready;
    assign load     = in_valid && in_ready && !flush;

    // One-entry pipeline register; flush wins over capture and drain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            ctrl_q  <= '0;
            pc_q    <= '0;
            imm_q   <= '0;
        end else if (flush) begin
            valid_q <= 1'b0;
        end else if (load) begin
            valid_q <= 1'b1;
            ctrl_q  <= dec;
            pc_q    <= in_pc;
            imm_q   <= imm_d;
        end else if (out_ready) begin
            valid_q <= 1'b0;
        end
    end

    assign out_valid = valid_q;
    assign out_pc    = pc_q;
    assign imm       = imm_q;
    assign rs1       = ctrl_q.rs1;
    assign rs2       = ctrl_q.rs2;
    assign rd        = ctrl_q.rd;
    assign funct3    = ctrl_q.funct3;
    assign alu_ctrl  = ALU_CTRL_W'(ctrl_q.alu_ctrl);
    assign alu_src   = ctrl_q.alu_src;
    assign alu_a_pc  = ctrl_q.alu_a_pc;
    assign res_src   = ctrl_q.res_src;
    assign mem_we    = ctrl_q.mem_we;
    assign mem_re    = ctrl_q.mem_re;
    assign reg_we    = ctrl_q.reg_we;
    assign branch    = ctrl_q.branch;
    assign jump      = ctrl_q.jump;
    assign jalr      = ctrl_q.jalr;
    assign illegal   = ctrl_q.illegal;

endmodule

// File: tb/tb_rv_decode_stage.sv
// Bench for rv_decode_stage: directed beats then randomized traffic, compared
// cycle by cycle against a mnemonic-level reference model of the stage.
module tb_rv_decode_stage;
    import rv_defs::*;

`ifdef RV_M_EXT_EN
    localparam bit M_EN = 1'b1;
`else
    localparam bit M_EN = 1'b0;
`endif

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_instr;
    logic [31:0] in_pc;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [4:0]  rs1, rs2, rd;
    logic [2:0]  funct3;
    logic [31:0] imm;
    logic [4:0]  alu_ctrl;
    logic        alu_src, alu_a_pc;
    logic [1:0]  res_src;
    logic        mem_we, mem_re, reg_we, branch, jump, jalr, illegal;

    rv_decode_stage #(.XLEN(32), .ALU_CTRL_W(5)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_instr(in_instr), .in_pc(in_pc), .flush(flush), .out_valid(out_valid),
        .out_ready(out_ready), .out_pc(out_pc), .rs1(rs1), .rs2(rs2), .rd(rd),
        .funct3(funct3), .imm(imm), .alu_ctrl(alu_ctrl), .alu_src(alu_src),
        .alu_a_pc(alu_a_pc), .res_src(res_src), .mem_we(mem_we), .mem_re(mem_re),
        .reg_we(reg_we), .branch(branch), .jump(jump), .jalr(jalr), .illegal(illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [4:0]  rs1, rs2, rd;
        logic [2:0]  f3;
        logic [31:0] imm;
        logic        imm_def;
        logic [4:0]  alu;
        logic        alu_src, alu_a_pc;
        logic [1:0]  res;
        logic        mem_we, mem_re, reg_we, branch, jump, jalr, illegal;
    } exp_t;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;
    exp_t        m;
    logic [31:0] m_pc;
    bit          m_valid;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
        n_checks++;
        if (got !== want) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, want, $time);
        end
    endtask

    function automatic logic [31:0] sext(input int unsigned v, input int bits);
        int r;
        r = int'(v);
        if (v >= (32'd1 << (bits - 1))) r = r - (1 << bits);
        return 32'(r);
    endfunction

    function automatic logic [4:0] reg_alu(input logic [2:0] f3);
        case (f3)
            3'd0: return ALU_ADD;  3'd1: return ALU_SLL;
            3'd2: return ALU_SLT;  3'd3: return ALU_SLTU;
            3'd4: return ALU_XOR;  3'd5: return ALU_SRL;
            3'd6: return ALU_OR;   default: return ALU_AND;
        endcase
    endfunction

    function automatic logic [4:0] m_alu(input logic [2:0] f3);
        case (f3)
            3'd0: return ALU_MUL;  3'd1: return ALU_MULH;
            3'd2: return ALU_MULHSU; 3'd3: return ALU_MULHU;
            3'd4: return ALU_DIV;  3'd5: return ALU_DIVU;
            3'd6: return ALU_REM;  default: return ALU_REMU;
        endcase
    endfunction

    // Reference decode from the instruction-set rules.
    function automatic exp_t ref_decode(input logic [31:0] ins);
        exp_t        e;
        logic [6:0]  op;
        logic [2:0]  f3;
        logic [6:0]  f7;
        bit          ok, wr;
        op = ins[6:0]; f3 = ins[14:12]; f7 = ins[31:25];
        e = '0;
        e.rs1 = ins[19:15]; e.rs2 = ins[24:20]; e.rd = ins[11:7]; e.f3 = f3;
        e.alu = ALU_ADD; e.imm_def = 1'b1;
        ok = 1'b1; wr = 1'b0;
        case (op)
            7'h33: begin
                wr = 1'b1; e.imm_def = 1'b0;
                if (f7 == 7'h00) e.alu = reg_alu(f3);
                else if (f7 == 7'h20 && f3 == 3'd0) e.alu = ALU_SUB;
                else if (f7 == 7'h20 && f3 == 3'd5) e.alu = ALU_SRA;
                else if (f7 == 7'h01 && M_EN) e.alu = m_alu(f3);
                else ok = 1'b0;
            end
            7'h13: begin
                wr = 1'b1; e.alu_src = 1'b1;
                e.imm = sext(ins[31:20], 12);
                e.alu = (f3 == 3'd5 && ins[30]) ? ALU_SRA : reg_alu(f3);
                if (f3 == 3'd1 && f7 != 7'h00) ok = 1'b0;
                if (f3 == 3'd5 && f7 != 7'h00 && f7 != 7'h20) ok = 1'b0;
            end
            7'h03: begin
                wr = 1'b1; e.alu_src = 1'b1; e.mem_re = 1'b1; e.res = 2'd1;
                e.imm = sext(ins[31:20], 12);
                ok = (f3 != 3'd3) && (f3 != 3'd6) && (f3 != 3'd7);
            end
            7'h23: begin
                e.alu_src = 1'b1; e.mem_we = 1'b1;
                e.imm = sext(ins[31:25] * 32 + ins[11:7], 12);
                ok = (f3 <= 3'd2);
            end
            7'h63: begin
                e.branch = 1'b1;
                e.imm = sext(ins[31] * 4096 + ins[7] * 2048 + ins[30:25] * 32 + ins[11:8] * 2, 13);
                e.alu = (f3 < 3'd2) ? ALU_SUB : (f3 < 3'd6) ? ALU_SLT : ALU_SLTU;
                ok = (f3 != 3'd2) && (f3 != 3'd3);
            end
            7'h6F: begin
                wr = 1'b1; e.jump = 1'b1; e.alu_src = 1'b1; e.alu_a_pc = 1'b1; e.res = 2'd2;
                e.imm = sext(ins[31] * (1 << 20) + ins[19:12] * 4096 + ins[20] * 2048
                             + ins[30:21] * 2, 21);
            end
            7'h67: begin
                wr = 1'b1; e.jump = 1'b1; e.jalr = 1'b1; e.alu_src = 1'b1; e.res = 2'd2;
                e.imm = sext(ins[31:20], 12);
                ok = (f3 == 3'd0);
            end
            7'h37: begin
                wr = 1'b1; e.alu_src = 1'b1; e.rs1 = 5'd0;
                e.imm = ins & 32'hFFFF_F000;
            end
            7'h17: begin
                wr = 1'b1; e.alu_src = 1'b1; e.alu_a_pc = 1'b1;
                e.imm = ins & 32'hFFFF_F000;
            end
            default: ok = 1'b0;
        endcase
        if (ins[1:0] != 2'b11) ok = 1'b0;
        e.reg_we  = wr && ok && (e.rd != 5'd0);
        e.illegal = !ok;
        if (!ok) begin
            e.mem_we = 1'b0; e.mem_re = 1'b0; e.branch = 1'b0; e.jump = 1'b0;
        end
        return e;
    endfunction

    task automatic check_outputs();
        check("out_valid", 64'(out_valid), 64'(m_valid));
        check("out_pc",    64'(out_pc),    64'(m_pc));
        check("rs1",       64'(rs1),       64'(m.rs1));
        check("rs2",       64'(rs2),       64'(m.rs2));
        check("rd",        64'(rd),        64'(m.rd));
        check("funct3",    64'(funct3),    64'(m.f3));
        check("illegal",   64'(illegal),   64'(m.illegal));
        check("strobes",   64'({reg_we, mem_we, mem_re, branch, jump}),
              64'({m.reg_we, m.mem_we, m.mem_re, m.branch, m.jump}));
        if (!m.illegal) begin
            check("alu_ctrl", 64'(alu_ctrl), 64'(m.alu));
            check("alu_sel",  64'({alu_src, alu_a_pc, jalr}), 64'({m.alu_src, m.alu_a_pc, m.jalr}));
            check("res_src",  64'(res_src),  64'(m.res));
            if (m.imm_def) check("imm", 64'(imm), 64'(m.imm));
        end
    endtask

    task automatic model_reset();
        m = '0; m.imm_def = 1'b1; m_pc = '0; m_valid = 1'b0;
    endtask

    // One cycle: drive at negedge, check held outputs and in_ready, advance model.
    task automatic cycle(input bit v, input logic [31:0] ins, input logic [31:0] pc,
                         input bit ordy, input bit fl);
        bit acc;
        @(negedge clk);
        in_valid = v; in_instr = ins; in_pc = pc; out_ready = ordy; flush = fl;
        #1;
        check_outputs();
        check("in_ready", 64'(in_ready), 64'(!m_valid || ordy));
        acc = v && (!m_valid || ordy) && !fl;
        if (fl) m_valid = 1'b0;
        else if (acc) begin m_valid = 1'b1; m = ref_decode(ins); m_pc = pc; end
        else if (ordy) m_valid = 1'b0;
    endtask

    function automatic logic [31:0] rand_instr();
        logic [31:0] r;
        logic [6:0]  ops [9];
        logic [6:0]  f7s [3];
        int          k;
        ops = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h6F, 7'h67, 7'h37, 7'h17};
        f7s = '{7'h00, 7'h20, 7'h01};
        r = $urandom();
        k = $urandom_range(0, 11);
        if (k < 9) r[6:0] = ops[k];
        else if (k == 9) r[1:0] = 2'($urandom_range(0, 2));
        if ((r[6:0] == 7'h33 || r[6:0] == 7'h13) && $urandom_range(0, 3) != 0)
            r[31:25] = f7s[$urandom_range(0, 2)];
        return r;
    endfunction

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; in_instr = '0; in_pc = '0;
        flush = 1'b0; out_ready = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed beats.
        cycle(1, 32'h002081B3, 32'h100, 1, 0);
        cycle(1, 32'h402081B3, 32'h104, 1, 0);
        cycle(1, 32'hFFF00093, 32'h108, 1, 0);
        check("addi_imm_all_ones", 64'(m.imm), 64'(32'hFFFF_FFFF));
        cycle(1, 32'h0020A423, 32'h10C, 1, 0);
        cycle(1, 32'h00000013, 32'h110, 0, 0);
        cycle(1, 32'h00000013, 32'h110, 0, 0);
        cycle(1, 32'h00000013, 32'h110, 0, 0);
        cycle(1, 32'h00000013, 32'h110, 1, 0);
        cycle(1, 32'h123452B7, 32'h114, 1, 0);
        cycle(1, 32'h0020A423, 32'h118, 0, 0);
        cycle(1, 32'hDEAD0537, 32'h11C, 0, 1);
        cycle(0, 32'h0, 32'h0, 1, 0);
        cycle(1, 32'h022081B3, 32'h120, 1, 0);
        cycle(1, 32'h00000000, 32'h124, 1, 0);
        cycle(0, 32'h0, 32'h0, 1, 0);

        // Asynchronous reset while a beat is held.
        cycle(1, 32'h00C58633, 32'h200, 0, 0);
        cycle(0, 32'h0, 32'h0, 0, 0);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("reset_out_valid", 64'(out_valid), 64'(0));
        check("reset_out_pc", 64'(out_pc), 64'(0));
        check("reset_reg_we", 64'(reg_we), 64'(0));
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;

        // Randomized traffic.
        for (int i = 0; i < 500; i++) begin
            cycle($urandom_range(0, 3) != 0, rand_instr(), $urandom() & 32'hFFFF_FFFC,
                  $urandom_range(0, 9) < 7, $urandom_range(0, 11) == 0);
        end
        cycle(0, 32'h0, 32'h0, 1, 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
